challengeqsys_mem_stream_reader: RTL and testbench
==================================================

Name: challengeqsys_mem_stream_reader

Overview:
Downstream consumer of the 32 KiB byte-wide on-chip RAM (s1-style port: 15-bit address, 8-bit data, fixed 1-cycle read latency, clken).
On a start command it reads a contiguous byte region from the RAM and emits it as an Avalon-ST packet with ready/valid backpressure.
It lets the challenge datapath consume a RAM-resident buffer at 1 byte/clk without stalling on memory latency.

Parameters:
ADDR_W, 15, RAM byte-address width (32768 words)
LEN_W, 16, transfer-length width; max legal length 32768
READ_LATENCY, 1, RAM read latency in clocks; legal 1..2
FIFO_DEPTH, READ_LATENCY+1, internal return-buffer depth; must not be smaller

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle command pulse; sampled only in IDLE
abort  in  1  cancel current transfer
base_addr  in  ADDR_W  first byte address
length  in  LEN_W  byte count
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
mem_address  out  ADDR_W  RAM address
mem_chipselect  out  1  RAM read strobe
mem_write  out  1  RAM write enable; constant 0
mem_clken  out  1  RAM clock enable
mem_readdata  in  8  RAM read data
st_data  out  8  stream byte
st_valid  out  1  stream valid
st_ready  in  1  stream ready
st_startofpacket  out  1  first byte of transfer
st_endofpacket  out  1  last byte of transfer

Behaviour:
- Reset, synchronous: state IDLE, FIFO emptied, in-flight tracker cleared. busy, done, st_valid, st_sop, st_eop and mem_chipselect are 0. mem_address is 0. mem_clken is 0 during reset and 1 otherwise.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start, latch base_addr and length, clear counters. Go to DONE if length==0, else READ. start while not IDLE is ignored.
  - READ: issue one read per clock while (fifo_count + inflight - pop) < FIFO_DEPTH. pop = st_valid & st_ready this cycle. After the issue of byte length-1, go to DRAIN.
  - DRAIN: no issues. Stay until the final byte handshakes, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy: 1 in READ/DRAIN/DONE, 0 in IDLE.
- Address generation: mem_address = base + issue_count, modulo 2^ADDR_W. Reads past 0x7FFF wrap to 0x0000. mem_chipselect is combinational with the issue condition.
- Read return: an in-flight shift register of READ_LATENCY bits marks valid returns. mem_readdata is captured into the FIFO in the cycle the tag emerges.
- FIFO: st_data and st_valid come from the FIFO head. Push and pop may occur in the same cycle. Overflow is impossible by the issue rule; any overflow is an assertion failure.
- Latency: with READ_LATENCY=1 and st_ready high, the first read issues 1 clock after the edge that samples start. st_valid rises 3 clocks after that edge. Sustained throughput is 1 byte/clk.
- st_startofpacket is 1 with byte 0; st_endofpacket is 1 with byte length-1. length==1 asserts both on the same beat.
- Backpressure: with st_valid=1 and st_ready=0, st_data, sop and eop hold stable. Issues stall once the FIFO plus in-flight count reaches FIFO_DEPTH.
- Abort, in READ or DRAIN: next cycle stop issuing, flush FIFO, drop in-flight returns, drive st_valid=0, and return to IDLE. No done pulse. An abort during DONE or IDLE has no effect.
- Counters are LEN_W wide. length > 32768 is illegal (assertion); the RAM contents then repeat through the wrap.

Decomposition:
- Package challengeqsys_stream_pkg: ADDR_W/LEN_W defaults, the FSM state enum (IDLE/READ/DRAIN/DONE), and the stream beat struct {data, sop, eop}.
- Sub-module challengeqsys_rd_skid_fifo: synchronous FIFO parameterised by DEPTH and the beat struct. It provides push, pop, count, full and empty, with simultaneous push/pop allowed.
- The FSM, address counter and in-flight tracker live in the top module.

Test Plan:
- RAM preloaded with mem[i]=i[7:0]. start, base=0x0010, length=4, st_ready=1 -> bytes 0x10,0x11,0x12,0x13 on consecutive cycles; sop on 0x10, eop on 0x13; done pulse 1 cycle after the 0x13 handshake; first st_valid 3 clocks after start.
- base=0x7FFE, length=4 -> addresses 0x7FFE,0x7FFF,0x0000,0x0001; data 0xFE,0xFF,0x00,0x01.
- length=16, st_ready toggled randomly (50%) -> all 16 bytes in order, none lost or duplicated, data held stable while st_ready=0; mem_chipselect never raised with FIFO plus in-flight ≥ 2.
- length=0 -> done pulse 2 clocks after start, no st_valid, no mem_chipselect; length=1 -> single beat with sop=eop=1.
- abort 5 cycles into a length=64 transfer, then reset asserted mid-transfer on a second run -> st_valid=0 next cycle, no done, busy=0; a new start with base=0x0100, length=2 then yields 0x00,0x01 (mem[0x100], mem[0x101]) with correct sop/eop.
- start pulsed again while busy -> ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/challengeqsys_stream_pkg.sv
// Shared defaults, FSM state encoding and stream beat type for the
// RAM-to-Avalon-ST reader.
package challengeqsys_stream_pkg;

    localparam int unsigned DEF_ADDR_W = 15;
    localparam int unsigned DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rd_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } stream_beat_t;

endpackage

// File: rtl/challengeqsys_rd_skid_fifo.sv
// Small synchronous return buffer for RAM read data; push and pop may occur
// in the same cycle, flush empties it immediately.
module challengeqsys_rd_skid_fifo
    import challengeqsys_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type beat_t = stream_beat_t,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  beat_t            push_data,
    input  logic             pop,
    output beat_t            pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    beat_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop frees the head slot in the same edge, so a full FIFO may still accept.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/challengeqsys_mem_stream_reader.sv
// Reads a contiguous byte region of the on-chip RAM and emits it as one
// Avalon-ST packet, issuing reads only when the return buffer has room.
module challengeqsys_mem_stream_reader
    import challengeqsys_stream_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned LEN_W        = DEF_LEN_W,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [7:0]        mem_readdata,
    output logic [7:0]        st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_startofpacket,
    output logic              st_endofpacket
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = 8;

    rd_state_e                 state;
    logic [ADDR_W-1:0]         base_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          issue_cnt;
    logic [LEN_W-1:0]          push_cnt;
    logic [READ_LATENCY-1:0]   infl_sr;
    logic [OCC_W-1:0]          infl_cnt;
    logic [OCC_W-1:0]          occ;
    logic                      issue;
    logic                      pop;
    logic                      push;
    logic                      abort_now;
    stream_beat_t              push_beat;
    stream_beat_t              head;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign pop       = st_valid && st_ready;
    assign push      = infl_sr[READ_LATENCY-1];
    assign abort_now = abort && ((state == READ) || (state == DRAIN));

    // Room check counts reads still in the RAM pipeline plus the slot freed by this cycle's pop.
    always_comb begin
        infl_cnt = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            infl_cnt = infl_cnt + OCC_W'(infl_sr[i]);
        end
        occ   = OCC_W'(fifo_count) + infl_cnt - OCC_W'(pop);
        issue = (state == READ) && (occ < OCC_W'(FIFO_DEPTH));
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = mem_readdata;
        push_beat.sop  = (push_cnt == '0);
        push_beat.eop  = (push_cnt == len_q - LEN_W'(1));
    end

    assign mem_address      = base_q + ADDR_W'(issue_cnt);
    assign mem_chipselect   = issue;
    assign mem_write        = 1'b0;
    assign mem_clken        = !reset;
    assign busy             = (state != IDLE);
    assign st_valid         = !fifo_empty;
    assign st_data          = head.data;
    assign st_startofpacket = st_valid && head.sop;
    assign st_endofpacket   = st_valid && head.eop;

    challengeqsys_rd_skid_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .beat_t (stream_beat_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_now),
        .push      (push),
        .push_data (push_beat),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            push_cnt  <= '0;
            infl_sr   <= '0;
            done      <= 1'b0;
        end else begin
            done       <= 1'b0;
            infl_sr[0] <= issue;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                infl_sr[i] <= infl_sr[i-1];
            end
            if (issue) begin
                issue_cnt <= issue_cnt + LEN_W'(1);
            end
            if (push) begin
                push_cnt <= push_cnt + LEN_W'(1);
            end
            if (abort_now) begin
                state   <= IDLE;
                infl_sr <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            assert (32'(length) <= (32'd1 << ADDR_W));
                            base_q    <= base_addr;
                            len_q     <= length;
                            issue_cnt <= '0;
                            push_cnt  <= '0;
                            state     <= (length == '0) ? DONE : READ;
                        end
                    end
                    READ: begin
                        if (issue && (issue_cnt == len_q - LEN_W'(1))) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop && head.eop) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_challengeqsys_mem_stream_reader.sv
// Directed bench for the RAM-to-stream reader against a 1-cycle-latency RAM
// model holding mem[i] = i[7:0].
module tb_challengeqsys_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [14:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic        mem_clken;
    logic [7:0]  mem_readdata = 8'h00;
    logic [7:0]  st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_startofpacket;
    logic        st_endofpacket;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [7:0]  ram [32768];

    logic [9:0]  beat_q [$];
    logic [14:0] addr_q [$];
    int          first_valid = -1;
    int          first_cs = -1;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_pop_cyc = 0;
    int          cs_cnt = 0;
    int          outstanding = 0;
    int          start_cyc = 0;
    bit          chk_occ = 1'b0;
    bit          rand_ready = 1'b0;
    bit          hold_prev = 1'b0;
    logic [10:0] hold_val = '0;

    challengeqsys_mem_stream_reader #(
        .ADDR_W       (15),
        .LEN_W        (16),
        .READ_LATENCY (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_startofpacket (st_startofpacket),
        .st_endofpacket   (st_endofpacket)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect && !mem_write) begin
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        st_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            st_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream observer: collects beats, timing marks, and checks hold/issue rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (hold_prev) begin
                check("hold", 32'({st_valid, st_data, st_startofpacket, st_endofpacket}), 32'(hold_val));
            end
            hold_prev = st_valid && !st_ready;
            hold_val  = {st_valid, st_data, st_startofpacket, st_endofpacket};
            if (mem_chipselect) begin
                if (chk_occ) begin
                    check("occ", 32'((outstanding - int'(st_valid && st_ready)) < 2), 32'd1);
                end
                cs_cnt++;
                if (first_cs < 0) first_cs = cyc;
                addr_q.push_back(mem_address);
            end
            outstanding = outstanding + int'(mem_chipselect) - int'(st_valid && st_ready);
            if (st_valid && first_valid < 0) first_valid = cyc;
            if (st_valid && st_ready) begin
                beat_q.push_back({st_data, st_startofpacket, st_endofpacket});
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic start_xfer(input logic [14:0] b, input logic [15:0] len);
        @(posedge clk);
        #1;
        beat_q.delete();
        addr_q.delete();
        first_valid = -1;
        first_cs    = -1;
        done_cnt    = 0;
        cs_cnt      = 0;
        outstanding = 0;
        base_addr   = b;
        length      = len;
        start       = 1'b1;
        start_cyc   = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input logic [14:0] b, input int len);
        logic [9:0]  bt;
        logic [14:0] a;
        check({tag, "_count"}, 32'(beat_q.size()), 32'(len));
        for (int i = 0; i < len && i < beat_q.size(); i++) begin
            bt = beat_q[i];
            a  = b + 15'(i);
            check({tag, "_data"}, 32'(bt[9:2]), 32'(a[7:0]));
            check({tag, "_flags"}, 32'(bt[1:0]), 32'({i == 0, i == len - 1}));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'(i);
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        length    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(st_valid), 32'd0);
        check("rst_sop_eop", 32'({st_startofpacket, st_endofpacket}), 32'd0);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_clken", 32'(mem_clken), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("run_clken", 32'(mem_clken), 32'd1);
        check("run_write", 32'(mem_write), 32'd0);

        // Basic transfer, ready held high.
        start_xfer(15'h0010, 16'd4);
        wait_done(40);
        check_stream("t1", 15'h0010, 4);
        check("t1_cs_lat", 32'(first_cs - start_cyc), 32'd1);
        check("t1_valid_lat", 32'(first_valid - start_cyc), 32'd3);
        check("t1_span", 32'(last_pop_cyc - first_valid), 32'd3);
        // Last handshake edge closes cycle h; done rises on the following edge.
        check("t1_done_lat", 32'(done_cyc - last_pop_cyc), 32'd2);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);

        // Address wrap at the top of the RAM.
        start_xfer(15'h7FFE, 16'd4);
        wait_done(40);
        check_stream("t2", 15'h7FFE, 4);
        check("t2_naddr", 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            check("t2_addr", 32'(addr_q[i]), 32'(15'(15'h7FFE + 15'(i))));
        end

        // Random backpressure.
        rand_ready = 1'b1;
        chk_occ    = 1'b1;
        start_xfer(15'h0040, 16'd16);
        wait_done(400);
        check_stream("t3", 15'h0040, 16);
        check("t3_reads", 32'(cs_cnt), 32'd16);
        chk_occ    = 1'b0;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Zero and single-byte lengths.
        start_xfer(15'h0050, 16'd0);
        wait_done(20);
        check("t4_done_lat", 32'(done_cyc - start_cyc), 32'd2);
        check("t4_valid_seen", 32'(first_valid >= 0), 32'd0);
        check("t4_cs", 32'(cs_cnt), 32'd0);
        start_xfer(15'h0123, 16'd1);
        wait_done(40);
        check_stream("t4b", 15'h0123, 1);

        // Abort mid-transfer.
        start_xfer(15'h0000, 16'd64);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("t5_pre_valid", 32'(st_valid), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(st_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check("t5_done", 32'(done_cnt), 32'd0);
        check("t5_valid_late", 32'(st_valid), 32'd0);
        check("t5_busy_late", 32'(busy), 32'd0);

        // Reset mid-transfer, then a fresh short transfer.
        start_xfer(15'h0000, 16'd64);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("t5r_clken", 32'(mem_clken), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5r_busy", 32'(busy), 32'd0);
        check("t5r_valid", 32'(st_valid), 32'd0);
        check("t5r_cs", 32'(mem_chipselect), 32'd0);
        check("t5r_addr", 32'(mem_address), 32'd0);
        check("t5r_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_xfer(15'h0100, 16'd2);
        wait_done(40);
        check_stream("t5n", 15'h0100, 2);

        // Second start while busy is ignored.
        start_xfer(15'h0200, 16'd8);
        @(posedge clk);
        #1;
        base_addr = 15'h0300;
        length    = 16'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(60);
        check_stream("t6", 15'h0200, 8);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_reads", 32'(cs_cnt), 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
